// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronize and deglitch the PS/2 pair, deframe 11-bit frames into a byte FIFO behind a 2-register bus port.
// Optional inactivity timeout between clock edges is compiled in with `define PS2_RX_TIMEOUT_EN.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_clk,
  input  logic       in_data,
  input  logic       addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       kb_int
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    sclk_q, sclk_d, sdat_q, sdat_d;
  logic [FW-1:0] fccnt_q, fccnt_d, fdcnt_q, fdcnt_d;
  logic          fclk_q, fclk_d, fdat_q, fdat_d, fclk_prev_q, fclk_prev_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          push_req_q, push_req_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          set_perr, set_ferr, tmo_hit;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic          int_en_q, int_en_d, kb_int_q, kb_int_d;
  logic          do_flush, do_pop, do_push, do_clr, not_empty, full;

  // Synchronizers, then a filter that flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sclk_d      = {sclk_q[0], in_clk};
    sdat_d      = {sdat_q[0], in_data};
    fclk_d      = fclk_q;
    fdat_d      = fdat_q;
    fccnt_d     = '0;
    fdcnt_d     = '0;
    fclk_prev_d = fclk_q;
    if (sclk_q[1] != fclk_q) begin
      if (fccnt_q == FW'(FILTER_LEN - 1)) fclk_d = sclk_q[1];
      else fccnt_d = fccnt_q + 1'b1;
    end
    if (sdat_q[1] != fdat_q) begin
      if (fdcnt_q == FW'(FILTER_LEN - 1)) fdat_d = sdat_q[1];
      else fdcnt_d = fdcnt_q + 1'b1;
    end
  end

  assign fall = fclk_prev_q & ~fclk_q;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (state_q == IDLE || fall) tmo_d = '0;
    else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
      tmo_hit = 1'b1;
      tmo_d   = '0;
    end else tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame deframer; a good frame is queued for the FIFO on the following cycle.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    push_req_d  = 1'b0;
    push_byte_d = push_byte_q;
    set_perr    = 1'b0;
    set_ferr    = 1'b0;
    if (tmo_hit) begin
      state_d  = IDLE;
      set_ferr = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: if (!fdat_q) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          shreg_d = {fdat_q, shreg_q[7:1]};
          if (bcnt_q == 3'd7) state_d = PARITY;
          else bcnt_d = bcnt_q + 1'b1;
        end
        PARITY: begin
          par_d   = fdat_q;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!(^{shreg_q, par_q})) set_perr = 1'b1;
          else if (!fdat_q) set_ferr = 1'b1;
          else begin
            push_req_d  = 1'b1;
            push_byte_d = shreg_q;
          end
        end
      endcase
    end
  end

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));

  // Flush beats both a coinciding pop and a coinciding push.
  always_comb begin
    do_flush = wr & addr & data_in[2];
    do_clr   = wr & addr & data_in[1];
    do_pop   = rd & ~addr & not_empty & ~do_flush;
    do_push  = push_req_q & ~do_flush & (~full | do_pop);
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    if (do_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_byte_q;
        wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    perr_d   = (do_clr ? 1'b0 : perr_q) | set_perr;
    ferr_d   = (do_clr ? 1'b0 : ferr_q) | set_ferr;
    ovf_d    = (do_clr ? 1'b0 : ovf_q) | (push_req_q & ~do_flush & full & ~do_pop);
    int_en_d = (wr & addr) ? data_in[0] : int_en_q;
    kb_int_d = int_en_q & not_empty;
  end

  always_comb begin
    if (addr)           data_out = {not_empty, full, ovf_q, ferr_q, perr_q, int_en_q, 2'b00};
    else if (not_empty) data_out = mem_q[rptr_q];
    else                data_out = 8'h00;
  end

  assign kb_int = kb_int_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q      <= 2'b11;
      sdat_q      <= 2'b11;
      fccnt_q     <= '0;
      fdcnt_q     <= '0;
      fclk_q      <= 1'b1;
      fdat_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      state_q     <= IDLE;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      push_req_q  <= 1'b0;
      push_byte_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      int_en_q    <= 1'b0;
      kb_int_q    <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      fccnt_q     <= fccnt_d;
      fdcnt_q     <= fdcnt_d;
      fclk_q      <= fclk_d;
      fdat_q      <= fdat_d;
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      push_req_q  <= push_req_d;
      push_byte_q <= push_byte_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      int_en_q    <= int_en_d;
      kb_int_q    <= kb_int_d;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames driven on in_clk/in_data, results read back over the register port.
module tb_ps2_kbd_rx;
  logic       clk = 1'b0, reset = 1'b0, in_clk = 1'b1, in_data = 1'b1;
  logic       addr = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0] data_in = 8'h00, data_out;
  logic       kb_int;
  int         n_cmp = 0, n_err = 0;

  ps2_kbd_rx #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .in_clk(in_clk), .in_data(in_data),
    .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(data_out), .kb_int(kb_int)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first nbits of the frame {stop, par, b, start}; glitch adds 1-cycle lows on in_clk.
  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop,
                           input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      in_data = fr[i];
      cyc(10);
      if (glitch) begin
        in_clk = 1'b0; cyc(1); in_clk = 1'b1;
      end
      cyc(10);
      in_clk = 1'b0;
      cyc(20);
      in_clk = 1'b1;
    end
    in_data = 1'b1;
    cyc(30);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, ~^b, 1'b1, 11, 1'b0);
  endtask

  task automatic peek(input logic a, output logic [7:0] v);
    @(negedge clk);
    addr = a; rd = 1'b0;
    #1 v = data_out;
  endtask

  task automatic pop(output logic [7:0] v);
    @(negedge clk);
    addr = 1'b0; rd = 1'b1;
    #1 v = data_out;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    cyc(3);
    addr = 1'b0; #1 v = data_out;
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", v); end
    addr = 1'b1; #1 v = data_out;
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_status got=%h exp=00", v); end
    n_cmp++; if (kb_int !== 1'b0) begin n_err++; $display("FAIL reset_kb_int got=%b exp=0", kb_int); end
    reset = 1'b1;
    cyc(5);
  endtask

  task automatic test_rx_int;
    logic [7:0] v;
    wr_reg(1'b1, 8'h01);
    send_bits(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    n_cmp++; if (kb_int !== 1'b1) begin n_err++; $display("FAIL rx_kb_int got=%b exp=1", kb_int); end
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h84) begin n_err++; $display("FAIL rx_status got=%h exp=84", v); end
    pop(v);
    n_cmp++; if (v !== 8'h1C) begin n_err++; $display("FAIL rx_data got=%h exp=1c", v); end
    cyc(1);
    n_cmp++; if (kb_int !== 1'b0) begin n_err++; $display("FAIL rx_kb_int_clr got=%b exp=0", kb_int); end
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h04) begin n_err++; $display("FAIL rx_status_empty got=%h exp=04", v); end
  endtask

  task automatic test_parity_err;
    logic [7:0] v;
    send_bits(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h0C) begin n_err++; $display("FAIL perr_status got=%h exp=0c", v); end
    n_cmp++; if (kb_int !== 1'b0) begin n_err++; $display("FAIL perr_kb_int got=%b exp=0", kb_int); end
    wr_reg(1'b1, 8'h02);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL perr_clear got=%h exp=00", v); end
  endtask

  task automatic test_framing_err;
    logic [7:0] v;
    send_bits(8'h33, 1'b1, 1'b0, 11, 1'b0);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h10) begin n_err++; $display("FAIL ferr_status got=%h exp=10", v); end
    send_bits(8'h33, 1'b0, 1'b0, 11, 1'b0);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h18) begin n_err++; $display("FAIL ferr_both got=%h exp=18", v); end
    wr_reg(1'b1, 8'h02);
  endtask

  task automatic test_overflow;
    logic [7:0] v;
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    peek(1'b1, v);
    n_cmp++; if (v !== 8'hE0) begin n_err++; $display("FAIL ovf_status got=%h exp=e0", v); end
    for (int i = 1; i <= 8; i++) begin
      pop(v);
      n_cmp++; if (v !== 8'(i)) begin n_err++; $display("FAIL ovf_read%0d got=%h exp=%h", i, v, 8'(i)); end
    end
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h20) begin n_err++; $display("FAIL ovf_drained got=%h exp=20", v); end
    wr_reg(1'b1, 8'h02);
  endtask

  task automatic test_flush;
    logic [7:0] v;
    send_byte(8'hA5);
    send_byte(8'h3C);
    wr_reg(1'b1, 8'h04);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL flush_status got=%h exp=00", v); end
    wr_reg(1'b0, 8'hFF);
    send_byte(8'h77);
    peek(1'b0, v);
    n_cmp++; if (v !== 8'h77) begin n_err++; $display("FAIL flush_after got=%h exp=77", v); end
    pop(v);
  endtask

  task automatic test_glitch;
    logic [7:0] v;
    send_bits(8'h5A, 1'b1, 1'b1, 11, 1'b1);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL glitch_status got=%h exp=80", v); end
    pop(v);
    n_cmp++; if (v !== 8'h5A) begin n_err++; $display("FAIL glitch_data got=%h exp=5a", v); end
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] v;
    send_bits(8'hFF, 1'b1, 1'b1, 5, 1'b0);
    cyc(1010);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h10) begin n_err++; $display("FAIL tmo_status got=%h exp=10", v); end
    wr_reg(1'b1, 8'h02);
    send_byte(8'h5A);
    pop(v);
    n_cmp++; if (v !== 8'h5A) begin n_err++; $display("FAIL tmo_data got=%h exp=5a", v); end
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL tmo_after got=%h exp=00", v); end
  endtask
`endif

  task automatic test_reset_midframe;
    logic [7:0] v;
    wr_reg(1'b1, 8'h01);
    send_bits(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    reset = 1'b0;
    cyc(5);
    reset = 1'b1;
    cyc(10);
    send_byte(8'h29);
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h80) begin n_err++; $display("FAIL rstmid_status got=%h exp=80", v); end
    pop(v);
    n_cmp++; if (v !== 8'h29) begin n_err++; $display("FAIL rstmid_data got=%h exp=29", v); end
    peek(1'b1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL rstmid_empty got=%h exp=00", v); end
  endtask

  initial begin
    test_reset();
    test_rx_int();
    test_parity_err();
    test_framing_err();
    test_overflow();
    test_flush();
    test_glitch();
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter FILTER_LEN, default 4, consecutive equal samples needed before filtered in_clk/in_data change.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000, clk cycles allowed between in_clk falling edges inside a frame.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_clk  input  1  PS/2 clock from keyboard, asynchronous.
REQ-007 SHALL have port in_data  input  1  PS/2 data from keyboard, asynchronous.
REQ-008 SHALL have port addr  input  1  register select: 0 data, 1 status/control.
REQ-009 SHALL have port rd  input  1  one-cycle read strobe, decoded upstream from chip select and cm0.
REQ-010 SHALL have port wr  input  1  one-cycle write strobe.
REQ-011 SHALL have port data_in  input  8  write data.
REQ-012 SHALL have port data_out  output  8  read data, combinational from addr.
REQ-013 SHALL have port kb_int  output  1  level interrupt request, active-high.

Function
REQ-014 SHALL pass in_clk and in_data through 2-flop synchronizers and then a FILTER_LEN-sample glitch filter; shorter pulses are ignored.
REQ-015 SHALL sample filtered in_data on each filtered in_clk falling edge.
REQ-016 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP; IDLE->DATA only on a sampled start bit 0 (a sampled 1 stays IDLE).
REQ-017 DATA SHALL shift 8 bits LSB first, then PARITY samples one bit, then STOP samples one bit, then returns to IDLE.
REQ-018 Frame SHALL be accepted only if the 8 data bits plus parity bit have odd weight and the stop bit is 1.
REQ-019 Parity failure SHALL set sticky parity_err and discard the byte; stop bit 0 SHALL set sticky framing_err and discard the byte; parity_err takes precedence if both fail.
REQ-020 Accepted byte SHALL be pushed into the FIFO one cycle after the stop-bit sample.
REQ-021 If the FIFO is full at push and no pop occurs that cycle, the new byte SHALL be dropped and sticky overflow set; FIFO contents unchanged.
REQ-022 Simultaneous push and pop SHALL both take effect, with count unchanged, including when full (no overflow).
REQ-023 addr=0 read SHALL return FIFO head (0x00 when empty); rd=1 with addr=0 and FIFO non-empty SHALL pop at that clock edge; pop on empty is ignored.
REQ-024 addr=1 read SHALL return status {not_empty, full, overflow, framing_err, parity_err, int_en, 2'b00}, with no side effects.
REQ-025 wr=1 with addr=1 SHALL load int_en=data_in[0]; data_in[1]=1 clears the three sticky flags; data_in[2]=1 flushes the FIFO. A push coinciding with flush SHALL be discarded.
REQ-026 wr with addr=0 SHALL have no effect.
REQ-027 kb_int SHALL equal int_en AND not_empty, registered (one cycle after the push or pop that changes it).

Reset
REQ-028 While reset is low: FSM=IDLE, FIFO empty, pointers 0, sticky flags 0, int_en=0, synchronizer/filter state 1, kb_int=0, data_out=0x00.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without setting any flag; the first frame after release SHALL be received normally.

Configuration
REQ-030 With macro PS2_RX_TIMEOUT_EN defined, a counter SHALL restart on every filtered in_clk falling edge while not IDLE, and on reaching TIMEOUT_CYCLES SHALL force IDLE, discard the partial byte and set framing_err.
REQ-031 Without PS2_RX_TIMEOUT_EN, no timeout logic SHALL exist and the FSM leaves non-IDLE states only through frame completion or reset.

Verification
REQ-032 int_en=1, send 0x1C with parity 0 and stop 1 -> kb_int=1, status=0x84, addr=0 read returns 0x1C and pops, kb_int=0 next cycle.
REQ-033 Send 0xF0 with parity 0 -> status[3]=1, FIFO empty, kb_int stays 0; write 0x02 to addr=1 -> status=0x00.
REQ-034 Send 9 valid bytes 0x01..0x09 without reading -> status[6:5]=2'b11, eight reads return 0x01..0x08.
REQ-035 Inject 1-cycle low glitches on in_clk during 0x5A frame -> 0x5A received intact, no error flags.
REQ-036 PS2_RX_TIMEOUT_EN defined: send 5 bits, stall TIMEOUT_CYCLES+10 -> framing_err=1, FIFO empty; then send 0x5A -> only 0x5A received.
REQ-037 Assert reset after 4 data bits, release, send 0x29 -> only 0x29 received, all flags 0.
